// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving the registered common data bus
// Define CDB_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority (debug/bring-up only).

package cdb_arbiter_pkg;
  typedef struct packed {
    logic [3:0] cr0;
    logic       xer_so;
    logic       xer_ov;
    logic       xer_ca;
  } cond_exception_t;
endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = 5,
  localparam int UNIT_W     = $clog2(UNITS),
  localparam int CX_W       = $bits(cond_exception_t)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [0:UNITS-1]             unit_valid,
  output logic [0:UNITS-1]             unit_ready,
  input  logic [UNITS*RS_ID_WIDTH-1:0] unit_rs_id,
  input  logic [UNITS*5-1:0]           unit_reg_addr,
  input  logic [UNITS*32-1:0]          unit_result,
  input  logic [UNITS*CX_W-1:0]        unit_cr0_xer,
  output logic                         cdb_valid,
  input  logic                         cdb_ready,
  output logic [RS_ID_WIDTH-1:0]       cdb_rs_id,
  output logic [4:0]                   cdb_reg_addr,
  output logic [31:0]                  cdb_result,
  output cond_exception_t              cdb_cr0_xer,
  output logic [UNIT_W-1:0]            cdb_unit
);

  logic                   cdb_valid_q, cdb_valid_d;
  logic [RS_ID_WIDTH-1:0] cdb_rs_id_q, cdb_rs_id_d;
  logic [4:0]             cdb_reg_addr_q, cdb_reg_addr_d;
  logic [31:0]            cdb_result_q, cdb_result_d;
  cond_exception_t        cdb_cr0_xer_q, cdb_cr0_xer_d;
  logic [UNIT_W-1:0]      cdb_unit_q, cdb_unit_d;
  logic [UNIT_W-1:0]      ptr_q, ptr_d;

  logic                   load_en;
  logic                   any_valid;
  logic                   transfer;
  logic [UNIT_W-1:0]      grant;
  logic [UNIT_W-1:0]      next_ptr;
  logic [RS_ID_WIDTH-1:0] sel_rs_id;
  logic [4:0]             sel_reg_addr;
  logic [31:0]            sel_result;
  cond_exception_t        sel_cr0_xer;

  assign load_en  = !cdb_valid_q || cdb_ready;
  assign transfer = load_en && any_valid;

  // Scan upward from ptr with wrap; in fixed-priority builds ptr stays 0,
  // which makes the same scan pick the lowest valid index.
  always_comb begin : grant_scan
    logic [UNIT_W-1:0] idx;
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < UNITS; k++) begin
      idx = UNIT_W'((int'(ptr_q) + k) % UNITS);
      if (!any_valid && unit_valid[idx]) begin
        any_valid = 1'b1;
        grant     = idx;
      end
    end
  end

`ifdef CDB_ARB_FIXED_PRIO_EN
  assign next_ptr = '0;
`else
  assign next_ptr = UNIT_W'((int'(grant) + 1) % UNITS);
`endif

  // Unit 0 sits in the most significant slice of each flattened payload bus.
  always_comb begin
    sel_rs_id    = '0;
    sel_reg_addr = '0;
    sel_result   = '0;
    sel_cr0_xer  = '0;
    for (int i = 0; i < UNITS; i++) begin
      if (UNIT_W'(i) == grant) begin
        sel_rs_id    = unit_rs_id[(UNITS-1-i)*RS_ID_WIDTH +: RS_ID_WIDTH];
        sel_reg_addr = unit_reg_addr[(UNITS-1-i)*5 +: 5];
        sel_result   = unit_result[(UNITS-1-i)*32 +: 32];
        sel_cr0_xer  = unit_cr0_xer[(UNITS-1-i)*CX_W +: CX_W];
      end
    end
  end

  always_comb begin
    unit_ready = '0;
    for (int i = 0; i < UNITS; i++) begin
      unit_ready[i] = rst && transfer && (UNIT_W'(i) == grant);
    end
  end

  always_comb begin
    cdb_valid_d    = cdb_valid_q;
    cdb_rs_id_d    = cdb_rs_id_q;
    cdb_reg_addr_d = cdb_reg_addr_q;
    cdb_result_d   = cdb_result_q;
    cdb_cr0_xer_d  = cdb_cr0_xer_q;
    cdb_unit_d     = cdb_unit_q;
    ptr_d          = ptr_q;
    if (load_en) begin
      cdb_valid_d = any_valid;
      if (any_valid) begin
        cdb_rs_id_d    = sel_rs_id;
        cdb_reg_addr_d = sel_reg_addr;
        cdb_result_d   = sel_result;
        cdb_cr0_xer_d  = sel_cr0_xer;
        cdb_unit_d     = grant;
        ptr_d          = next_ptr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_q    <= 1'b0;
      cdb_rs_id_q    <= '0;
      cdb_reg_addr_q <= '0;
      cdb_result_q   <= '0;
      cdb_cr0_xer_q  <= '0;
      cdb_unit_q     <= '0;
      ptr_q          <= '0;
    end else begin
      cdb_valid_q    <= cdb_valid_d;
      cdb_rs_id_q    <= cdb_rs_id_d;
      cdb_reg_addr_q <= cdb_reg_addr_d;
      cdb_result_q   <= cdb_result_d;
      cdb_cr0_xer_q  <= cdb_cr0_xer_d;
      cdb_unit_q     <= cdb_unit_d;
      ptr_q          <= ptr_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_rs_id    = cdb_rs_id_q;
  assign cdb_reg_addr = cdb_reg_addr_q;
  assign cdb_result   = cdb_result_q;
  assign cdb_cr0_xer  = cdb_cr0_xer_q;
  assign cdb_unit     = cdb_unit_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) result broadcast between the execution-unit wrappers (rotate, add, logical, multiply, ...). Each wrapper's ready-valid result port is one requester; the winner's result is registered and driven onto the CDB. The CDB feeds the `update_op_*` ports of every reservation station and the register-file writeback. The block is a one-entry registered stage with backpressure from the writeback side.

## Interface
Parameters:
- `UNITS`, 4: number of requesting execution units, must be ≥ 2.
- `RS_ID_WIDTH`, 5: width of the reservation-station ID carried with each result.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. The block is in reset while `rst`=0.
- `unit_valid`  in  `UNITS`  per-unit result valid; bit 0 is unit 0 (MSB-first, `[0:UNITS-1]`).
- `unit_ready`  out  `UNITS`  per-unit accept; at most one bit high per cycle.
- `unit_rs_id`  in  `UNITS*RS_ID_WIDTH`  per-unit RS ID; unit 0 is in the most significant slice.
- `unit_reg_addr`  in  `UNITS*5`  per-unit destination GPR address.
- `unit_result`  in  `UNITS*32`  per-unit 32-bit result.
- `unit_cr0_xer`  in  `UNITS*$bits(cond_exception_t)`  per-unit CR0/XER update.
- `cdb_valid`  out  1  broadcast valid.
- `cdb_ready`  in  1  writeback accepts the broadcast.
- `cdb_rs_id`  out  `RS_ID_WIDTH`  RS ID of the broadcast result.
- `cdb_reg_addr`  out  5  destination GPR address.
- `cdb_result`  out  32  result value.
- `cdb_cr0_xer`  out  `cond_exception_t`  CR0/XER update.
- `cdb_unit`  out  `$clog2(UNITS)`  index of the unit that produced the current broadcast.

## Operation
- Output stage: a single register holding `{valid, rs_id, reg_addr, result, cr0_xer, unit}`.
- `load_en = !cdb_valid || cdb_ready`.
- Grant is combinational. Scan `unit_valid` starting at `ptr` and moving upward, wrapping from `UNITS-1` to 0. The first set bit is the grant `g`.
- `unit_ready[i] = load_en && any_valid && (i == g)`.
- Transfer occurs when `unit_valid[g] && unit_ready[g]`. On a transfer:
  - unit `g`'s payload is loaded into the output register;
  - `cdb_valid` is set to 1;
  - `cdb_unit` is set to `g`;
  - `ptr` is set to `(g+1) mod UNITS`.
- When `load_en` is high and no unit is valid: `cdb_valid` is set to 0, the payload registers hold their values, and `ptr` holds.
- When `load_en` is low (`cdb_valid && !cdb_ready`): all output registers and `ptr` hold, and every `unit_ready` bit is 0.
- `ptr` wraps using a modulo computation, so it is correct for non-power-of-two `UNITS`.
- `unit_ready` depends combinationally on `unit_valid`. Units must not make `unit_valid` depend on `unit_ready`.
- Units hold their payload stable while valid and not accepted; the arbiter does not re-check this.

## Timing
- Reset values: `cdb_valid`=0, `cdb_rs_id`=0, `cdb_reg_addr`=0, `cdb_result`=0, `cdb_cr0_xer`=0, `cdb_unit`=0, `ptr`=0. `unit_ready` evaluates to 0 while `rst`=0.
- Reset asserted mid-operation: a pending broadcast is dropped immediately (asynchronously), with no handshake.
- Latency: a unit accepted in cycle N appears on the CDB in cycle N+1.
- Throughput: one result per cycle while `cdb_ready`=1.
- Back-to-back: in a cycle where `cdb_valid && cdb_ready`, a new winner is loaded in the same cycle, so there is no bubble.
- Fairness: with all `UNITS` continuously valid and `cdb_ready`=1, each unit is granted exactly once in every `UNITS` consecutive cycles.
- Simultaneous events: when a unit raises valid in the same cycle `ptr` points at it, that unit wins in that cycle.
- Stall: while `cdb_ready`=0, the CDB payload is stable and no unit is accepted.

## Configuration
- `CDB_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. Lowest valid index wins, and `ptr` is tied to 0 and never updated. Unit 0 can starve others; this mode is intended for debug and bring-up.
  - Undefined (default): round-robin exactly as described under Operation.

## Test plan
- Reset: `rst`=0 with all units valid. Expect `cdb_valid`=0, `unit_ready`=0, all CDB outputs 0. Release reset: the first grant goes to unit 0.
- Single unit: only unit 2 valid, result `32'hDEADBEEF`, rs_id 5, reg 7, `cdb_ready`=1. Expect `unit_ready`=`4'b0010` in cycle N. In cycle N+1: `cdb_valid`=1, `cdb_result`=`32'hDEADBEEF`, `cdb_rs_id`=5, `cdb_reg_addr`=7, `cdb_unit`=2.
- Round-robin: all 4 units continuously valid, `cdb_ready`=1. Expect `cdb_unit` sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Backpressure: `cdb_ready`=0 for 3 cycles while `cdb_valid`=1. Expect payload stable and `unit_ready`=0 throughout. When `cdb_ready` returns to 1, the next unit is accepted in that same cycle.
- Wrap with sparse requests: `ptr`=3, only units 1 and 3 valid. Expect grant to unit 3, then unit 1, after which `ptr`=2.
- Compiled with `CDB_ARB_FIXED_PRIO_EN`: units 0 and 3 continuously valid. Expect `cdb_unit`=0 on every cycle and unit 3 never accepted.
